// File: rtl/iob_vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// iob_vga_pixel_fetch: reads framebuffer pixels ahead of the VGA stage into a
// show-ahead pixel FIFO, with frame restart and sticky underflow reporting.
// Rev 1.0
// ============================================================================
module iob_vga_pixel_fetch #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned FRAME_PIXELS = 307200,
  parameter int unsigned PIX_STRIDE   = 2,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        frame_sync,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [15:0] mem_rsp_data,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [15:0] pixel,
  output logic        underflow
);

  localparam int unsigned c_ptr_w = $clog2(FIFO_DEPTH);
  // Wide enough for fifo_count + outstanding plus one late request accepted in FLUSH
  localparam int unsigned c_cnt_w = c_ptr_w + 2;
  localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);
  localparam logic [31:0]        c_stride    = 32'(PIX_STRIDE);
  localparam logic [31:0]        c_last_addr = BASE_ADDR + 32'((FRAME_PIXELS - 1) * PIX_STRIDE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_req_valid;
  logic [31:0]        r_req_addr;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_fifo_count;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [15:0]        r_fifo_mem [FIFO_DEPTH];
  logic               r_underflow;

  logic               w_req_hs;
  logic               w_req_stall;
  logic               w_rsp_dec;
  logic               w_flush_entry;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_addr_incr;
  logic [c_cnt_w-1:0] w_outstanding_next;
  logic [c_cnt_w-1:0] w_fifo_count_next;
  logic [c_cnt_w-1:0] w_inflight_next;

  assign w_req_hs      = r_req_valid & mem_req_ready;
  assign w_req_stall   = r_req_valid & ~mem_req_ready;
  assign w_rsp_dec     = mem_rsp_valid & (r_outstanding != '0);
  assign w_flush_entry = (r_state == S_FETCH) & (frame_sync | ~enable);
  assign w_push        = (r_state == S_FETCH) & ~w_flush_entry & mem_rsp_valid;
  assign w_pop         = pix_valid & pix_ready;
  assign w_addr_incr   = (r_req_addr == c_last_addr) ? BASE_ADDR : r_req_addr + c_stride;

  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;
  assign pix_valid     = (r_state == S_FETCH) && (r_fifo_count != '0);
  assign pixel         = pix_valid ? r_fifo_mem[r_rd_ptr] : 16'h0000;
  assign underflow     = r_underflow;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (enable && r_outstanding == '0) w_state_next = S_FETCH;
      S_FETCH: if (w_flush_entry) w_state_next = S_FLUSH;
      // A stalled request must be accepted (and its response drained) before leaving
      S_FLUSH: if (r_outstanding == '0 && !r_req_valid)
                 w_state_next = enable ? S_FETCH : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    w_outstanding_next = r_outstanding;
    if (w_req_hs && !w_rsp_dec)
      w_outstanding_next = r_outstanding + c_cnt_w'(1);
    else if (!w_req_hs && w_rsp_dec)
      w_outstanding_next = r_outstanding - c_cnt_w'(1);

    if (w_flush_entry)
      w_fifo_count_next = '0;
    else
      w_fifo_count_next = r_fifo_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

    w_inflight_next = w_fifo_count_next + w_outstanding_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_req_valid   <= 1'b0;
      r_req_addr    <= BASE_ADDR;
      r_outstanding <= '0;
      r_fifo_count  <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_underflow   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_outstanding_next;
      r_fifo_count  <= w_fifo_count_next;

      if (w_flush_entry) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end

      // Reserve a FIFO slot for every request so responses can never overflow
      if (w_req_stall)
        r_req_valid <= 1'b1;
      else
        r_req_valid <= (w_state_next == S_FETCH) && (w_inflight_next < c_depth);

      if (w_req_hs)
        r_req_addr <= (r_state == S_FETCH && !w_flush_entry) ? w_addr_incr : BASE_ADDR;
      else if (!r_req_valid && (w_flush_entry || (r_state != S_FETCH && frame_sync)))
        r_req_addr <= BASE_ADDR;

      if (frame_sync)
        r_underflow <= 1'b0;
      else if (r_state == S_FETCH && pix_ready && !pix_valid)
        r_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= mem_rsp_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// tb_iob_vga_pixel_fetch: scoreboard bench with an in-order response memory.
// Rev 1.0
// ============================================================================
module tb_iob_vga_pixel_fetch;

  localparam logic [31:0] c_base   = 32'h0000_0000;
  localparam int unsigned c_frame  = 4;
  localparam int unsigned c_stride = 2;
  localparam int unsigned c_depth  = 16;
  localparam logic [31:0] c_last   = c_base + 32'((c_frame - 1) * c_stride);

  typedef struct packed {
    logic [31:0] epoch;
    logic [15:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_sync = 1'b0;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = 16'h0000;
  logic        pix_ready = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        pix_valid;
  logic [15:0] pixel;
  logic        underflow;

  rsp_t        rsp_q[$];
  logic [15:0] exp_pix_q[$];
  rsp_t        mon_e;
  logic [15:0] mon_exp;
  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;
  int          pop_count = 0;
  logic [31:0] epoch = 32'd0;
  logic [31:0] m_addr = c_base;
  logic        stale = 1'b0;
  logic        rsp_en = 1'b1;

  iob_vga_pixel_fetch #(
    .BASE_ADDR   (c_base),
    .FRAME_PIXELS(c_frame),
    .PIX_STRIDE  (c_stride),
    .FIFO_DEPTH  (c_depth)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .frame_sync   (frame_sync),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .pix_ready    (pix_ready),
    .pix_valid    (pix_valid),
    .pixel        (pixel),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Pixel scoreboard and in-order memory, both evaluated on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_q.delete();
      mem_rsp_valid = 1'b0;
    end else begin
      if (!pix_valid) begin
        checks++;
        if (pixel !== 16'h0000) begin
          errors++;
          $display("FAIL pixel_when_invalid got %h want 0000", pixel);
        end
      end else if (pix_ready) begin
        checks++;
        pop_count++;
        if (exp_pix_q.size() == 0) begin
          errors++;
          $display("FAIL pixel_pop got %h want nothing (no pixel expected)", pixel);
        end else begin
          mon_exp = exp_pix_q.pop_front();
          if (pixel !== mon_exp) begin
            errors++;
            $display("FAIL pixel_order got %h want %h", pixel, mon_exp);
          end
        end
      end

      if (rsp_en && rsp_q.size() > 0) begin
        mon_e = rsp_q.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mon_e.data;
        if (mon_e.epoch == epoch) exp_pix_q.push_back(mon_e.data);
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 16'($urandom);
      end

      if (mem_req_valid && mem_req_ready) begin
        checks++;
        if (mem_req_addr !== m_addr) begin
          errors++;
          $display("FAIL req_addr got %h want %h", mem_req_addr, m_addr);
        end
        mon_e.data  = {8'(hs_count), mem_req_addr[7:0]};
        mon_e.epoch = stale ? epoch - 32'd1 : epoch;
        rsp_q.push_back(mon_e);
        hs_count++;
        m_addr = (stale || m_addr == c_last) ? c_base : m_addr + 32'(c_stride);
        stale  = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A frame restart or disable: everything in flight now belongs to the old frame
  task automatic model_sync();
    epoch++;
    exp_pix_q.delete();
    if (mem_req_valid) stale = 1'b1;
    else m_addr = c_base;
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    model_sync();
    step();
    frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; frame_sync = 1'b0;
    mem_req_ready = 1'b0; pix_ready = 1'b0; rsp_en = 1'b1;
    epoch++; exp_pix_q.delete(); m_addr = c_base; stale = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic issue_n(input int n);
    int start;
    int guard;
    start = hs_count;
    guard = 0;
    mem_req_ready = 1'b1;
    while (hs_count - start < n && guard < 200) begin
      step();
      guard++;
    end
    mem_req_ready = 1'b0;
    checks++;
    if (hs_count - start != n) begin
      errors++;
      $display("FAIL issue_n accepted %0d want %0d", hs_count - start, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", mem_req_valid); end
    checks++; if (mem_req_addr !== c_base) begin errors++; $display("FAIL reset_req_addr got %h want %h", mem_req_addr, c_base); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
    checks++; if (pixel !== 16'h0000) begin errors++; $display("FAIL reset_pixel got %h want 0000", pixel); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", underflow); end
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_no_request got %b want 0", mem_req_valid); end
  endtask

  task automatic test_fill();
    int h0;
    do_reset();
    h0 = hs_count;
    enable = 1'b1; mem_req_ready = 1'b1;
    repeat (40) step();
    checks++; if (hs_count - h0 != 16) begin errors++; $display("FAIL fill_requests got %0d want 16", hs_count - h0); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL fill_stops got %b want 0", mem_req_valid); end
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL fill_pix_valid got %b want 1", pix_valid); end
  endtask

  task automatic test_stream();
    int p0;
    p0 = pop_count;
    pix_ready = 1'b1;
    repeat (60) step();
    pix_ready = 1'b0;
    checks++; if (pop_count - p0 != 60) begin errors++; $display("FAIL stream_pops got %0d want 60", pop_count - p0); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL stream_underflow got %b want 0", underflow); end
  endtask

  task automatic test_enable_toggle();
    int p0;
    enable = 1'b0;
    model_sync();
    step();
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL disable_pix_valid got %b want 0", pix_valid); end
    repeat (6) step();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL disable_idle_req got %b want 0", mem_req_valid); end
    enable = 1'b1;
    repeat (30) step();
    p0 = pop_count;
    pix_ready = 1'b1;
    repeat (20) step();
    pix_ready = 1'b0;
    checks++; if (pop_count - p0 != 20) begin errors++; $display("FAIL reenable_pops got %0d want 20", pop_count - p0); end
  endtask

  task automatic test_flush();
    int p0;
    do_reset();
    enable = 1'b1;
    issue_n(5);
    repeat (3) step();
    rsp_en = 1'b0;
    issue_n(3);
    step();
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b want 1", pix_valid); end
    pulse_sync();
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL flush_fifo_empty got %b want 0", pix_valid); end
    pix_ready = 1'b1;
    repeat (4) step();
    pix_ready = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL flush_no_underflow got %b want 0", underflow); end
    rsp_en = 1'b1; mem_req_ready = 1'b1;
    repeat (40) step();
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL flush_restart_valid got %b want 1", pix_valid); end
    p0 = pop_count;
    pix_ready = 1'b1;
    repeat (20) step();
    pix_ready = 1'b0;
    checks++; if (pop_count - p0 != 20) begin errors++; $display("FAIL flush_restart_pops got %0d want 20", pop_count - p0); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL flush_restart_underflow got %b want 0", underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    pix_ready = 1'b1;
    step(); step();
    pix_ready = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL idle_ignores_ready got %b want 0", underflow); end
    enable = 1'b1;
    step(); step();
    pix_ready = 1'b1;
    step(); step();
    pix_ready = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got %b want 1", underflow); end
    checks++; if (pixel !== 16'h0000) begin errors++; $display("FAIL underflow_pixel got %h want 0000", pixel); end
    step(); step();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got %b want 1", underflow); end
    pulse_sync();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear got %b want 0", underflow); end
  endtask

  task automatic test_stall_sync();
    int h0;
    logic [31:0] held;
    do_reset();
    enable = 1'b1;
    issue_n(2);
    step();
    held = m_addr;
    pulse_sync();
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_hold got %b want 1", mem_req_valid); end
      checks++; if (mem_req_addr !== held) begin errors++; $display("FAIL stall_addr_hold got %h want %h", mem_req_addr, held); end
      step();
    end
    h0 = hs_count;
    mem_req_ready = 1'b1;
    repeat (40) step();
    checks++; if (hs_count - h0 != 17) begin errors++; $display("FAIL stall_refill_requests got %0d want 17", hs_count - h0); end
    pix_ready = 1'b1;
    repeat (10) step();
    pix_ready = 1'b0;
  endtask

  task automatic test_reset_full();
    repeat (30) step();
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL prereset_full got %b want 1", pix_valid); end
    rst_n = 1'b0;
    epoch++; exp_pix_q.delete(); m_addr = c_base; stale = 1'b0;
    step();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL midreset_req_valid got %b want 0", mem_req_valid); end
    checks++; if (mem_req_addr !== c_base) begin errors++; $display("FAIL midreset_req_addr got %h want %h", mem_req_addr, c_base); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL midreset_pix_valid got %b want 0", pix_valid); end
    checks++; if (pixel !== 16'h0000) begin errors++; $display("FAIL midreset_pixel got %h want 0000", pixel); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL midreset_underflow got %b want 0", underflow); end
    rst_n = 1'b1;
    enable = 1'b0;
    mem_req_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_enable_toggle();
    test_flush();
    test_underflow();
    test_stall_sync();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iob_vga_pixel_fetch.md
IOB_VGA_PIXEL_FETCH -- requirements
Module: iob_vga_pixel_fetch

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first framebuffer pixel.
REQ-002 SHALL have parameter FRAME_PIXELS, default 307200, pixels per frame.
REQ-003 SHALL have parameter PIX_STRIDE, default 2, byte address increment per pixel.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of 2, >=4).
REQ-005 SHALL have port clk  in  1  sole clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-007 SHALL have port enable  in  1  fetch enable.
REQ-008 SHALL have port frame_sync  in  1  single-cycle pulse; restart the frame at BASE_ADDR.
REQ-009 SHALL have port mem_req_valid  out  1  read request valid.
REQ-010 SHALL have port mem_req_ready  in  1  memory accepts the request.
REQ-011 SHALL have port mem_req_addr  out  32  byte address of the requested pixel.
REQ-012 SHALL have port mem_rsp_valid  in  1  read data valid; responses return in request order, one per request.
REQ-013 SHALL have port mem_rsp_data  in  16  pixel data, {4'bx, R[3:0], G[3:0], B[3:0]}.
REQ-014 SHALL have port pix_ready  in  1  downstream VGA stage consumes one pixel this cycle.
REQ-015 SHALL have port pix_valid  out  1  FIFO head holds a valid pixel.
REQ-016 SHALL have port pixel  out  16  FIFO head data; 16'h0000 when pix_valid=0.
REQ-017 SHALL have port underflow  out  1  sticky flag: a pixel was consumed while the FIFO was empty.

Function
REQ-018 SHALL implement states IDLE, FETCH and FLUSH.
REQ-019 IDLE->FETCH SHALL occur when enable=1 and outstanding=0.
REQ-020 FETCH->FLUSH SHALL occur on frame_sync=1 or enable=0.
REQ-021 FLUSH->FETCH SHALL occur when outstanding=0 and enable=1; FLUSH->IDLE SHALL occur when outstanding=0 and enable=0.
REQ-022 SHALL hold outstanding, a count of accepted requests without a response: +1 on mem_req_valid&mem_req_ready, -1 on mem_rsp_valid, net 0 when both occur in the same cycle.
REQ-023 SHALL assert mem_req_valid in FETCH only when fifo_count+outstanding<FIFO_DEPTH, so the FIFO can never overflow.
REQ-024 Once mem_req_valid is asserted, mem_req_valid and mem_req_addr SHALL hold stable until the handshake completes, regardless of state change.
REQ-025 mem_req_addr SHALL advance by PIX_STRIDE on each handshake; after the handshake at BASE_ADDR+(FRAME_PIXELS-1)*PIX_STRIDE it SHALL wrap to BASE_ADDR.
REQ-026 In FETCH, mem_rsp_data SHALL be written to the FIFO on mem_rsp_valid and be visible on pixel/pix_valid on the next cycle (1-cycle latency).
REQ-027 In FLUSH, responses SHALL be discarded; only outstanding SHALL be decremented.
REQ-028 pixel/pix_valid SHALL be a show-ahead FIFO head; pix_ready&pix_valid SHALL pop one entry.
REQ-029 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-030 pix_ready=1 with pix_valid=0 in FETCH SHALL set underflow; the FIFO SHALL remain unchanged and pixel SHALL read 16'h0000.
REQ-031 underflow SHALL clear only on reset or frame_sync.
REQ-032 On entering FLUSH, the FIFO SHALL be emptied and the address counter set to BASE_ADDR, except that a pending un-acknowledged request follows REQ-024.
REQ-033 In FLUSH and IDLE, pix_valid SHALL be 0 and pix_ready SHALL be ignored (no underflow).
REQ-034 frame_sync received in FLUSH or IDLE SHALL reset the address counter to BASE_ADDR and clear underflow, with no other effect.

Reset
REQ-035 With rst_n=0 at a clock edge: state=IDLE, mem_req_valid=0, mem_req_addr=BASE_ADDR, outstanding=0, FIFO empty, pix_valid=0, pixel=16'h0000, underflow=0.
REQ-036 Reset SHALL abandon in-flight requests; the environment SHALL reset the memory side concurrently.

Verification
REQ-037 Enable with mem_req_ready=1 and a 1-cycle response memory -> addresses 0,2,4,... issued; issuing stops at fifo_count+outstanding=16 with pix_ready=0.
REQ-038 FRAME_PIXELS=4, continuous pix_ready -> addresses 0,2,4,6,0,2; pixel sequence matches memory contents in order; underflow=0 after the initial fill.
REQ-039 frame_sync with 3 outstanding and the FIFO holding 5 entries -> FIFO empty next cycle; 3 responses dropped; after the 3rd response, FETCH restarts at address 0.
REQ-040 pix_ready=1 for 2 cycles at startup before the first response -> underflow=1, pixel=0; a later frame_sync clears underflow.
REQ-041 mem_req_ready held 0 for 5 cycles during frame_sync -> mem_req_addr stable until accepted; that response is discarded.
REQ-042 rst_n=0 mid-frame with FIFO full -> all outputs take their REQ-035 values on the next edge.
